// File: rtl/mcp2515_spi_master.sv
// mcp2515_spi_master
// Byte-streaming SPI master for one or more MCP2515 CAN controllers.
// A transaction selects one chip select, then moves 1..MAX_BYTES bytes with
// per-byte TX/RX handshakes, SCK half-period of CLK_DIV clk50 cycles.
//
// Handshakes (valid/ready):
//   tx: a byte transfers on any clk50 edge where tx_valid && tx_ready are both
//       high. tx_ready is high only in LOAD; tx_data must be stable while
//       tx_valid is high. tx_valid may be held low indefinitely (engine stalls).
//   rx: rx_valid is a one-cycle pulse with no back-pressure; rx_data stays
//       valid until the next received byte.
//   start: accepted only while busy=0 and the request is legal.
//
// Optional build macro:
//   MCP2515_SPI_LOOPBACK_EN -- sample si instead of so (bring-up without a device).
//
// Parameter legality (CLK_DIV>=2, SPI_MODE in {0,3}, N_CS>=1) is the
// instantiator's responsibility.
module mcp2515_spi_master #(
  parameter int CLK_DIV   = 4,
  parameter int SPI_MODE  = 0,
  parameter int N_CS      = 2,
  parameter int MAX_BYTES = 16,
  parameter int CS_W      = (N_CS > 1) ? $clog2(N_CS) : 1,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk50,
  input  logic             rst,
  input  logic             start,
  input  logic [CS_W-1:0]  cs_sel,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic [N_CS-1:0]  cs,
  output logic             sck,
  output logic             si,
  input  logic             so,
  output logic [2:0]       dbg_state
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic SCK_IDLE = (SPI_MODE == 3) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;         // cycles within the current phase
  logic [2:0]        bit_q, bit_d;         // bit index within the byte
  logic              ph_q, ph_d;           // 0: low half of bit period, 1: high half
  logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [6:0]        tx_sh_q, tx_sh_d;     // bits still to be driven after si
  logic [7:0]        rx_sh_q, rx_sh_d;
  logic              rx_pend_q, rx_pend_d; // 8th sample just taken
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              done_q, done_d;
  logic [N_CS-1:0]   cs_q, cs_d;
  logic              sck_q, sck_d;
  logic              si_q, si_d;

  logic [N_CS-1:0]   cs_sel_n;
  logic              start_ok;
  logic              sample_bit;

`ifdef MCP2515_SPI_LOOPBACK_EN
  // Loopback: the received stream is whatever we are driving on si.
  logic unused_so;
  assign unused_so  = so;
  assign sample_bit = si_q;
`else
  assign sample_bit = so;
`endif

  // Active-low chip-select pattern for the requested device.
  always_comb begin
    cs_sel_n = '1;
    for (int i = 0; i < N_CS; i++) begin
      if (int'(cs_sel) == i) cs_sel_n[i] = 1'b0;
    end
  end

  assign start_ok = start && (len != '0) && (int'(len) <= MAX_BYTES) &&
                    (int'(cs_sel) < N_CS);

  // Next-state and datapath: one bit period is a low half then a high half,
  // so mode 3 gets its leading falling edge on entry to SHIFT for free.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    ph_d       = ph_q;
    byte_cnt_d = byte_cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_pend_d  = 1'b0;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    done_d     = 1'b0;
    cs_d       = cs_q;
    sck_d      = sck_q;
    si_d       = si_q;

    // Publish the completed byte one cycle after its last sample.
    if (rx_pend_q) begin
      rx_data_d  = rx_sh_q;
      rx_valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        sck_d = SCK_IDLE;
        cs_d  = '1;
        if (start_ok) begin
          state_d    = ST_SETUP;
          cnt_d      = '0;
          byte_cnt_d = len;
          cs_d       = cs_sel_n;
        end
      end

      ST_SETUP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_LOAD: begin
        if (tx_valid) begin
          tx_sh_d = tx_data[6:0];
          si_d    = tx_data[7];
          cnt_d   = '0;
          bit_d   = 3'd0;
          ph_d    = 1'b0;
          sck_d   = 1'b0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!ph_q) begin
            // Rising edge: sample the incoming bit.
            ph_d      = 1'b1;
            sck_d     = 1'b1;
            rx_sh_d   = {rx_sh_q[6:0], sample_bit};
            rx_pend_d = (bit_q == 3'd7);
          end else if (bit_q == 3'd7) begin
            // End of the 8th high half: park sck, si keeps the LSB.
            sck_d      = SCK_IDLE;
            byte_cnt_d = byte_cnt_q - LEN_W'(1);
            state_d    = (byte_cnt_q == LEN_W'(1)) ? ST_HOLD : ST_LOAD;
          end else begin
            // Falling edge: present the next bit.
            bit_d   = bit_q + 3'd1;
            ph_d    = 1'b0;
            sck_d   = 1'b0;
            si_d    = tx_sh_q[6];
            tx_sh_d = {tx_sh_q[5:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          cs_d    = '1;
          done_d  = 1'b1;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_GAP: begin
        // Chip-select deselect time before the next transaction.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cs_d    = '1;
        sck_d   = SCK_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk50) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= 3'd0;
      ph_q       <= 1'b0;
      byte_cnt_q <= '0;
      tx_sh_q    <= 7'd0;
      rx_sh_q    <= 8'd0;
      rx_pend_q  <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      cs_q       <= '1;
      sck_q      <= SCK_IDLE;
      si_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      ph_q       <= ph_d;
      byte_cnt_q <= byte_cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_pend_q  <= rx_pend_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      si_q       <= si_d;
    end
  end

  assign tx_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign done      = done_q;
  assign cs        = cs_q;
  assign sck       = sck_q;
  assign si        = si_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mcp2515_spi_master.sv
// tb_mcp2515_spi_master
// Directed bench: dut0 runs SPI mode 0, dut1 runs SPI mode 3, both CLK_DIV=4, N_CS=2.
// All bench activity happens on the falling clk50 edge.
`timescale 1ns/1ps
module tb_mcp2515_spi_master;

  // ---------------- clock / reset ----------------
  logic clk50 = 1'b0;
  always #10 clk50 = ~clk50;
  logic rst;

  // ---------------- dut0 (mode 0) ----------------
  logic       start0, tx_valid0, tx_ready0, rx_valid0, busy0, done0, sck0, si0, so0;
  logic [0:0] cs_sel0;
  logic [4:0] len0;
  logic [7:0] tx_data0, rx_data0;
  logic [1:0] cs0;
  logic [2:0] dbg0;

  mcp2515_spi_master #(.CLK_DIV(4), .SPI_MODE(0), .N_CS(2), .MAX_BYTES(16)) dut0 (
    .clk50(clk50), .rst(rst), .start(start0), .cs_sel(cs_sel0), .len(len0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .busy(busy0), .done(done0),
    .cs(cs0), .sck(sck0), .si(si0), .so(so0), .dbg_state(dbg0)
  );

  // ---------------- dut1 (mode 3) ----------------
  logic       start1, tx_valid1, tx_ready1, rx_valid1, busy1, done1, sck1, si1, so1;
  logic [0:0] cs_sel1;
  logic [4:0] len1;
  logic [7:0] tx_data1, rx_data1;
  logic [1:0] cs1;
  logic [2:0] dbg1;

  mcp2515_spi_master #(.CLK_DIV(4), .SPI_MODE(3), .N_CS(2), .MAX_BYTES(16)) dut1 (
    .clk50(clk50), .rst(rst), .start(start1), .cs_sel(cs_sel1), .len(len1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1), .done(done1),
    .cs(cs1), .sck(sck1), .si(si1), .so(so1), .dbg_state(dbg1)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] tx_pat [8];
  logic [7:0] so_pat [8];
  logic [7:0] exp_q    [$];
  logic [7:0] exp_si_q [$];
  logic [7:0] rx_got_q [$];
  logic [7:0] si_got_q [$];

  logic       sck0_prev, sck1_prev, busy0_prev;
  logic [1:0] cs0_prev, cs_exp_low;
  logic [7:0] si_sh0, si_sh1, rx1_last;
  int rise0, rise1, first_rise_cyc, last_rise_cyc, period;
  int done_cnt0, done_cnt1, rx1_cnt, cs_bad, cs_rise_cyc, busy_fall_cyc;

  // Expected received byte: the device byte normally, the sent byte in loopback.
  function automatic logic [7:0] exp_rx(input logic [7:0] t, input logic [7:0] s);
`ifdef MCP2515_SPI_LOOPBACK_EN
    return t;
`else
    return s;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: wait for the falling edge, then run the monitors and the device model.
  task automatic tick();
    @(negedge clk50);
    cyc++;
    if (sck0 && !sck0_prev) begin
      if (rise0 == 0) first_rise_cyc = cyc;
      else if (rise0 == 1) period = cyc - last_rise_cyc;
      last_rise_cyc = cyc;
      si_sh0 = {si_sh0[6:0], si0};
      rise0++;
      if (rise0 % 8 == 0) si_got_q.push_back(si_sh0);
    end
    sck0_prev = sck0;
    // MCP2515 model: next bit presented after each sampling edge
    so0 = so_pat[(rise0 / 8) % 8][7 - (rise0 % 8)];
    if (rx_valid0) rx_got_q.push_back(rx_data0);
    if (done0) done_cnt0++;
    if (cs0 != 2'b11 && cs0 != cs_exp_low) cs_bad++;
    if (cs0 == 2'b11 && cs0_prev != 2'b11) cs_rise_cyc = cyc;
    if (!busy0 && busy0_prev) busy_fall_cyc = cyc;
    cs0_prev   = cs0;
    busy0_prev = busy0;
    if (sck1 && !sck1_prev) begin
      si_sh1 = {si_sh1[6:0], si1};
      rise1++;
    end
    sck1_prev = sck1;
    if (rx_valid1) begin rx1_cnt++; rx1_last = rx_data1; end
    if (done1) done_cnt1++;
  endtask

  task automatic clear_mon();
    rise0 = 0; first_rise_cyc = -1; last_rise_cyc = -1; period = -1;
    done_cnt0 = 0; cs_bad = 0; cs_rise_cyc = -1; busy_fall_cyc = -1;
    si_sh0 = 8'h00;
    rx_got_q.delete(); si_got_q.delete(); exp_q.delete(); exp_si_q.delete();
  endtask

  // Driver for dut0. stall_byte/stall_cyc hold tx_valid low before that byte;
  // inject drives illegal starts mid-transfer and throughout HOLD/GAP.
  task automatic run0(input logic [0:0] sel, input int n, input int stall_byte,
                      input int stall_cyc, input logic inject,
                      output int start_cyc, output int stall_bad, output logic timeout);
    int k;
    int st;
    k = 0; st = 0; stall_bad = 0; timeout = 1'b1;
    cs_exp_low = sel ? 2'b01 : 2'b10;
    start0 = 1'b1; cs_sel0 = sel; len0 = 5'(n); start_cyc = cyc;
    tick();
    start0 = 1'b0;
    for (int it = 0; it < 3000; it++) begin
      start0 = 1'b0;
      if (inject && (it == 20 || dbg0 == 3'd4 || dbg0 == 3'd5)) begin
        start0 = 1'b1; cs_sel0 = ~sel; len0 = 5'd3;
      end
      if (tx_ready0 && k < n) begin
        if (k == stall_byte && st < stall_cyc) begin
          tx_valid0 = 1'b0;
          st++;
          if (cs0 != cs_exp_low || sck0 != 1'b0) stall_bad++;
        end else begin
          tx_valid0 = 1'b1;
          tx_data0  = tx_pat[k];
          k++;
        end
      end else begin
        tx_valid0 = 1'b0;
      end
      tick();
      if (!busy0 && done_cnt0 > 0) begin
        timeout = 1'b0;
        break;
      end
    end
    tx_valid0 = 1'b0;
    start0    = 1'b0;
  endtask

  // Scoreboard drain: received bytes and bytes seen on si against expectations.
  task automatic chk_queues(input string tag);
    chk({tag, "_rx_count"}, rx_got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && rx_got_q.size() > 0)
      chk({tag, "_rx_byte"}, rx_got_q.pop_front(), exp_q.pop_front());
    chk({tag, "_si_count"}, si_got_q.size(), exp_si_q.size());
    while (exp_si_q.size() > 0 && si_got_q.size() > 0)
      chk({tag, "_si_byte"}, si_got_q.pop_front(), exp_si_q.pop_front());
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int   scyc, sbad, bad;
    logic to;
    logic sck1_at_load;

    rst = 1'b1;
    start0 = 1'b0; cs_sel0 = 1'b0; len0 = 5'd0; tx_data0 = 8'h00; tx_valid0 = 1'b0; so0 = 1'b0;
    start1 = 1'b0; cs_sel1 = 1'b0; len1 = 5'd0; tx_data1 = 8'h00; tx_valid1 = 1'b0; so1 = 1'b0;
    for (int i = 0; i < 8; i++) begin tx_pat[i] = 8'h00; so_pat[i] = 8'h00; end
    sck0_prev = 1'b0; sck1_prev = 1'b1; busy0_prev = 1'b0; cs0_prev = 2'b11;
    cs_exp_low = 2'b11; rise1 = 0; si_sh1 = 8'h00; done_cnt1 = 0; rx1_cnt = 0; rx1_last = 8'h00;
    clear_mon();

    // Reset held three cycles while idle
    repeat (3) tick();
    chk("rst_cs", cs0, 2'b11);
    chk("rst_sck0", sck0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_rx_data", rx_data0, 8'h00);
    chk("rst_si", si0, 1'b0);
    chk("rst_ctrl", {tx_ready0, rx_valid0, done0}, 3'b000);
    chk("rst_sck1_idle_high", sck1, 1'b1);
    rst = 1'b0;
    repeat (2) tick();

    // Two bytes to device 1: A0 then 00, device returns FF then 5A
    clear_mon();
    tx_pat[0] = 8'hA0; tx_pat[1] = 8'h00; so_pat[0] = 8'hFF; so_pat[1] = 8'h5A;
    exp_q.push_back(exp_rx(8'hA0, 8'hFF)); exp_q.push_back(exp_rx(8'h00, 8'h5A));
    exp_si_q.push_back(8'hA0); exp_si_q.push_back(8'h00);
    run0(1'b1, 2, -1, 0, 1'b0, scyc, sbad, to);
    chk("t1_timeout", to, 1'b0);
    chk("t1_latency", first_rise_cyc - scyc, 10);
    chk("t1_sck_period", period, 8);
    chk("t1_rises", rise0, 16);
    chk("t1_done_once", done_cnt0, 1);
    chk("t1_busy_after_cs", busy_fall_cyc - cs_rise_cyc, 4);
    chk("t1_cs_only_one", cs_bad, 0);
    chk_queues("t1");

    // Stall 50 cycles before byte 2, device 0
    clear_mon();
    tx_pat[0] = 8'h3C; tx_pat[1] = 8'hC3; so_pat[0] = 8'h81; so_pat[1] = 8'h7E;
    exp_q.push_back(exp_rx(8'h3C, 8'h81)); exp_q.push_back(exp_rx(8'hC3, 8'h7E));
    exp_si_q.push_back(8'h3C); exp_si_q.push_back(8'hC3);
    run0(1'b0, 2, 1, 50, 1'b0, scyc, sbad, to);
    chk("t2_timeout", to, 1'b0);
    chk("t2_stall_cs_sck", sbad, 0);
    chk("t2_done_once", done_cnt0, 1);
    chk("t2_cs_only_one", cs_bad, 0);
    chk_queues("t2");

    // Mode 3, one byte 0x03
    rise1 = 0; si_sh1 = 8'h00; done_cnt1 = 0; rx1_cnt = 0; sck1_at_load = 1'b0; to = 1'b1;
    chk("t3_sck_idle_before", sck1, 1'b1);
    start1 = 1'b1; cs_sel1 = 1'b0; len1 = 5'd1;
    tick();
    start1 = 1'b0;
    for (int it = 0; it < 1000; it++) begin
      if (tx_ready1) begin
        sck1_at_load = sck1;
        tx_valid1 = 1'b1; tx_data1 = 8'h03;
      end else begin
        tx_valid1 = 1'b0;
      end
      tick();
      if (!busy1 && done_cnt1 > 0) begin to = 1'b0; break; end
    end
    tx_valid1 = 1'b0;
    chk("t3_timeout", to, 1'b0);
    chk("t3_sck_high_in_load", sck1_at_load, 1'b1);
    chk("t3_rises", rise1, 8);
    chk("t3_si_byte", si_sh1, 8'h03);
    chk("t3_sck_idle_after", sck1, 1'b1);
    chk("t3_cs_after", cs1, 2'b11);
    chk("t3_done_once", done_cnt1, 1);
    chk("t3_rx_count", rx1_cnt, 1);
    chk("t3_rx_byte", rx1_last, exp_rx(8'h03, 8'h00));

    // Illegal starts: len=0 and len>MAX_BYTES
    clear_mon();
    bad = 0;
    start0 = 1'b1; cs_sel0 = 1'b1; len0 = 5'd0;
    tick();
    start0 = 1'b1; len0 = 5'd17;
    tick();
    start0 = 1'b0;
    repeat (12) begin
      tick();
      if (cs0 != 2'b11 || busy0 != 1'b0) bad++;
    end
    chk("t4_illegal_len_ignored", bad, 0);

    // Start while busy (mid-byte and around done) must not disturb the transfer
    clear_mon();
    tx_pat[0] = 8'h55; so_pat[0] = 8'hC3;
    exp_q.push_back(exp_rx(8'h55, 8'hC3)); exp_si_q.push_back(8'h55);
    run0(1'b1, 1, -1, 0, 1'b1, scyc, sbad, to);
    chk("t4_timeout", to, 1'b0);
    chk("t4_done_once", done_cnt0, 1);
    chk("t4_rises", rise0, 8);
    chk("t4_cs_unchanged", cs_bad, 0);
    chk_queues("t4");
    bad = 0;
    repeat (20) begin
      tick();
      if (busy0 != 1'b0 || cs0 != 2'b11) bad++;
    end
    chk("t4_no_restart", bad, 0);

    // Reset after the 4th sample of byte 1
    clear_mon();
    tx_pat[0] = 8'hF0; so_pat[0] = 8'hFF;
    cs_exp_low = 2'b01;
    to = 1'b1;
    start0 = 1'b1; cs_sel0 = 1'b1; len0 = 5'd1;
    tick();
    start0 = 1'b0;
    for (int it = 0; it < 200; it++) begin
      tx_valid0 = tx_ready0;
      tx_data0  = tx_pat[0];
      tick();
      if (rise0 >= 4) begin to = 1'b0; break; end
    end
    tx_valid0 = 1'b0;
    chk("t5_reached_bit4", to, 1'b0);
    rst = 1'b1;
    tick();
    chk("t5_cs_reset", cs0, 2'b11);
    chk("t5_outputs_reset", {sck0, si0, busy0, tx_ready0, rx_valid0, done0}, 6'b000000);
    rst = 1'b0;
    repeat (60) tick();
    chk("t5_no_done", done_cnt0, 0);
    chk("t5_no_rx_valid", rx_got_q.size(), 0);
    clear_mon();
    tx_pat[0] = 8'h96; so_pat[0] = 8'h69;
    exp_q.push_back(exp_rx(8'h96, 8'h69)); exp_si_q.push_back(8'h96);
    run0(1'b1, 1, -1, 0, 1'b0, scyc, sbad, to);
    chk("t5_timeout", to, 1'b0);
    chk("t5_done_once", done_cnt0, 1);
    chk("t5_rx_data_reg", rx_data0, exp_rx(8'h96, 8'h69));
    chk_queues("t5");

    // Three bytes, device drives 0 (loopback build returns the sent bytes)
    clear_mon();
    tx_pat[0] = 8'h12; tx_pat[1] = 8'h34; tx_pat[2] = 8'h56;
    so_pat[0] = 8'h00; so_pat[1] = 8'h00; so_pat[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(exp_rx(tx_pat[i], 8'h00));
      exp_si_q.push_back(tx_pat[i]);
    end
    run0(1'b0, 3, -1, 0, 1'b0, scyc, sbad, to);
    chk("t6_timeout", to, 1'b0);
    chk("t6_done_once", done_cnt0, 1);
    chk("t6_rises", rise0, 24);
    chk_queues("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
